retire_trace_buffer: RTL and testbench

- Sits directly downstream of the write-back stage of the 5-stage MIPS pipeline.
- Captures each architecturally retired instruction and its destination-register write into a FIFO.
- Streams the captured records to a trace consumer (co-simulation checker or debug port) over a valid/ready handshake.
- Counts retirements and detects the end-of-test syscall ($v0 == 0xa).

---
 rtl/retire_trace_buffer.sv | 143 ++++++++++++++
 tb/tb_retire_trace_buffer.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/retire_trace_buffer.sv
// Retire trace buffer: captures WB-stage retirements into a FIFO and streams them to a trace consumer.
// Latency: a record pushed on edge N is on trace_* in cycle N+1; trace_* is driven from storage only, never from retire_*.
// Backpressure: trace_* holds while trace_ready=0; a retire arriving on a full FIFO with no pop is dropped and counted.
//
// Ports:
//   clk, reset                 clock; asynchronous active-high reset
//   retire_valid/pc/instr      WB retirement strobe, PC and instruction word
//   retire_we/waddr/wdata      WB register-file write
//   reg_v0                     current $v0, used to spot the end-of-test syscall
//   trace_valid/ready          head-record handshake to the consumer
//   trace_pc/instr/we/waddr/wdata  head record fields (0 while empty)
//   retire_count               accepted records (wraps)
//   drop_count                 records lost to overflow (saturates)
//   overflow, halted           sticky status flags
module retire_trace_buffer #(
  parameter int DEPTH = 16,
  parameter int DEDUP = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        retire_valid,
  input  logic [31:0] retire_pc,
  input  logic [31:0] retire_instr,
  input  logic        retire_we,
  input  logic [4:0]  retire_waddr,
  input  logic [31:0] retire_wdata,
  input  logic [31:0] reg_v0,
  output logic        trace_valid,
  input  logic        trace_ready,
  output logic [31:0] trace_pc,
  output logic [31:0] trace_instr,
  output logic        trace_we,
  output logic [4:0]  trace_waddr,
  output logic [31:0] trace_wdata,
  output logic [31:0] retire_count,
  output logic [15:0] drop_count,
  output logic        overflow,
  output logic        halted
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] LP_FULL = (AW+1)'(DEPTH);

  // Record storage; not reset, since entries are only observed while r_count says they are live.
  logic [31:0] r_pc_mem    [0:DEPTH-1];
  logic [31:0] r_instr_mem [0:DEPTH-1];
  logic        r_we_mem    [0:DEPTH-1];
  logic [4:0]  r_waddr_mem [0:DEPTH-1];
  logic [31:0] r_wdata_mem [0:DEPTH-1];

  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic [31:0]   r_retire_cnt;
  logic [15:0]   r_drop_cnt;
  logic          r_overflow;
  logic          r_halted;
  logic          r_prev_vld;
  logic [31:0]   r_prev_pc;
  logic [31:0]   r_prev_instr;

  logic w_cand;
  logic w_dup;
  logic w_new;
  logic w_full;
  logic w_pop;
  logic w_push;
  logic w_reject;
  logic w_halt;
  logic w_rec_we;

  // Bubbles (instr 0) never reach the trace; nothing is accepted once halted.
  assign w_cand   = retire_valid && (retire_instr != 32'd0) && !r_halted;
  // A stalled WB stage re-presents the same instruction; only the first copy is kept.
  assign w_dup    = (DEDUP != 0) && r_prev_vld &&
                    (retire_pc == r_prev_pc) && (retire_instr == r_prev_instr);
  assign w_new    = w_cand && !w_dup;
  assign w_full   = (r_count == LP_FULL);
  assign w_pop    = trace_valid && trace_ready;
  // At full, a same-cycle pop frees the slot the push lands in.
  assign w_push   = w_new && (!w_full || w_pop);
  assign w_reject = w_new && w_full && !w_pop;
  assign w_halt   = w_new && (retire_instr == 32'h0000000C) && (reg_v0 == 32'h0000000A);
  // $zero writes are architecturally no-ops, so they are recorded as no-write.
  assign w_rec_we = retire_we && (retire_waddr != 5'd0);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_pc_mem[r_wr_ptr]    <= retire_pc;
      r_instr_mem[r_wr_ptr] <= retire_instr;
      r_we_mem[r_wr_ptr]    <= w_rec_we;
      r_waddr_mem[r_wr_ptr] <= retire_waddr;
      r_wdata_mem[r_wr_ptr] <= w_rec_we ? retire_wdata : 32'd0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_retire_cnt <= 32'd0;
      r_drop_cnt   <= 16'd0;
      r_overflow   <= 1'b0;
      r_halted     <= 1'b0;
      r_prev_vld   <= 1'b0;
      r_prev_pc    <= 32'd0;
      r_prev_instr <= 32'd0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: ;
      endcase
      if (w_push) begin
        r_retire_cnt <= r_retire_cnt + 32'd1;
        r_prev_vld   <= 1'b1;
        r_prev_pc    <= retire_pc;
        r_prev_instr <= retire_instr;
      end
      if (w_reject) begin
        r_overflow <= 1'b1;
        if (r_drop_cnt != 16'hFFFF) r_drop_cnt <= r_drop_cnt + 16'd1;
      end
      if (w_halt) r_halted <= 1'b1;
    end
  end

  // Head fields are forced to 0 while empty so the stale memory is never visible.
  assign trace_valid  = (r_count != '0);
  assign trace_pc     = trace_valid ? r_pc_mem[r_rd_ptr]    : 32'd0;
  assign trace_instr  = trace_valid ? r_instr_mem[r_rd_ptr] : 32'd0;
  assign trace_we     = trace_valid ? r_we_mem[r_rd_ptr]    : 1'b0;
  assign trace_waddr  = trace_valid ? r_waddr_mem[r_rd_ptr] : 5'd0;
  assign trace_wdata  = trace_valid ? r_wdata_mem[r_rd_ptr] : 32'd0;
  assign retire_count = r_retire_cnt;
  assign drop_count   = r_drop_cnt;
  assign overflow     = r_overflow;
  assign halted       = r_halted;

endmodule

// File: tb/tb_retire_trace_buffer.sv
// Bench for retire_trace_buffer: two instances (DEDUP=1 and DEDUP=0) share one stimulus stream.
// A queue-based reference model predicts records and counters; a negedge monitor compares.
// Stimulus changes 1 time unit after each rising edge; the monitor samples at the falling edge.
module tb_retire_trace_buffer;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        retire_valid = 1'b0;
  logic [31:0] retire_pc = '0;
  logic [31:0] retire_instr = '0;
  logic        retire_we = 1'b0;
  logic [4:0]  retire_waddr = '0;
  logic [31:0] retire_wdata = '0;
  logic [31:0] reg_v0 = '0;
  logic        trace_ready = 1'b0;

  logic        tv [2];
  logic [31:0] tpc [2];
  logic [31:0] tin [2];
  logic        twe [2];
  logic [4:0]  twa [2];
  logic [31:0] twd [2];
  logic [31:0] rcnt [2];
  logic [15:0] dcnt [2];
  logic        ovf [2];
  logic        hlt [2];

  always #5 clk = ~clk;

  retire_trace_buffer #(.DEPTH(DEPTH), .DEDUP(1)) u_dut0 (
    .clk(clk), .reset(reset), .retire_valid(retire_valid), .retire_pc(retire_pc),
    .retire_instr(retire_instr), .retire_we(retire_we), .retire_waddr(retire_waddr),
    .retire_wdata(retire_wdata), .reg_v0(reg_v0), .trace_valid(tv[0]), .trace_ready(trace_ready),
    .trace_pc(tpc[0]), .trace_instr(tin[0]), .trace_we(twe[0]), .trace_waddr(twa[0]),
    .trace_wdata(twd[0]), .retire_count(rcnt[0]), .drop_count(dcnt[0]), .overflow(ovf[0]),
    .halted(hlt[0]));

  retire_trace_buffer #(.DEPTH(DEPTH), .DEDUP(0)) u_dut1 (
    .clk(clk), .reset(reset), .retire_valid(retire_valid), .retire_pc(retire_pc),
    .retire_instr(retire_instr), .retire_we(retire_we), .retire_waddr(retire_waddr),
    .retire_wdata(retire_wdata), .reg_v0(reg_v0), .trace_valid(tv[1]), .trace_ready(trace_ready),
    .trace_pc(tpc[1]), .trace_instr(tin[1]), .trace_we(twe[1]), .trace_waddr(twa[1]),
    .trace_wdata(twd[1]), .retire_count(rcnt[1]), .drop_count(dcnt[1]), .overflow(ovf[1]),
    .halted(hlt[1]));

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
  } rec_t;

  // Reference model state, one slot per instance.
  rec_t        sb0[$];
  rec_t        sb1[$];
  int          m_cnt [2];
  logic [31:0] m_ret [2];
  int          m_drop [2];
  bit          m_ovf [2];
  bit          m_halt [2];
  bit          m_pv [2];
  logic [31:0] m_ppc [2];
  logic [31:0] m_pin [2];

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    sb0.delete();
    sb1.delete();
    for (int k = 0; k < 2; k++) begin
      m_cnt[k] = 0; m_ret[k] = 0; m_drop[k] = 0;
      m_ovf[k] = 0; m_halt[k] = 0; m_pv[k] = 0; m_ppc[k] = 0; m_pin[k] = 0;
    end
  endtask

  // Applies the effect of one rising edge, using the inputs present at that edge.
  task automatic model_edge();
    bit   pop, cand, dup;
    rec_t r;
    for (int k = 0; k < 2; k++) begin
      pop  = (m_cnt[k] > 0) && trace_ready;
      cand = retire_valid && (retire_instr != 0) && !m_halt[k];
      dup  = (k == 0) && m_pv[k] && (retire_pc == m_ppc[k]) && (retire_instr == m_pin[k]);
      if (cand && !dup) begin
        if (m_cnt[k] < DEPTH || pop) begin
          r.pc    = retire_pc;
          r.instr = retire_instr;
          r.we    = retire_we && (retire_waddr != 0);
          r.waddr = retire_waddr;
          r.wdata = r.we ? retire_wdata : 32'd0;
          if (k == 0) sb0.push_back(r); else sb1.push_back(r);
          m_cnt[k]++;
          m_ret[k] = m_ret[k] + 1;
          m_pv[k]  = 1;
          m_ppc[k] = retire_pc;
          m_pin[k] = retire_instr;
        end else begin
          m_ovf[k] = 1;
          if (m_drop[k] < 65535) m_drop[k]++;
        end
        if (retire_instr == 32'h0000000C && reg_v0 == 32'h0000000A) m_halt[k] = 1;
      end
      if (pop) m_cnt[k]--;
    end
  endtask

  // Monitor: compares head record and status against the model each cycle.
  always @(negedge clk) begin : mon
    rec_t e;
    bit   have;
    if (!reset) begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("valid%0d", k), {31'd0, tv[k]}, {31'd0, m_cnt[k] > 0});
        if (tv[k] === 1'b1) begin
          have = (k == 0) ? (sb0.size() > 0) : (sb1.size() > 0);
          n_cmp++;
          if (!have) begin
            n_err++;
            $display("FAIL head%0d: valid with pc %h but no record expected", k, tpc[k]);
          end else begin
            e = (k == 0) ? sb0[0] : sb1[0];
            chk($sformatf("pc%0d", k), tpc[k], e.pc);
            chk($sformatf("instr%0d", k), tin[k], e.instr);
            chk($sformatf("we%0d", k), {31'd0, twe[k]}, {31'd0, e.we});
            chk($sformatf("waddr%0d", k), {27'd0, twa[k]}, {27'd0, e.waddr});
            chk($sformatf("wdata%0d", k), twd[k], e.wdata);
            if (trace_ready) begin
              if (k == 0) void'(sb0.pop_front()); else void'(sb1.pop_front());
            end
          end
        end
        chk($sformatf("retire_count%0d", k), rcnt[k], m_ret[k]);
        chk($sformatf("drop_count%0d", k), {16'd0, dcnt[k]}, m_drop[k]);
        chk($sformatf("overflow%0d", k), {31'd0, ovf[k]}, {31'd0, m_ovf[k]});
        chk($sformatf("halted%0d", k), {31'd0, hlt[k]}, {31'd0, m_halt[k]});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic put(input logic [31:0] pc, input logic [31:0] instr, input logic we,
                     input logic [4:0] wa, input logic [31:0] wd);
    retire_valid = 1'b1; retire_pc = pc; retire_instr = instr;
    retire_we = we; retire_waddr = wa; retire_wdata = wd;
    tick();
  endtask

  task automatic idle(input int n);
    retire_valid = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic zero_checks(input string tag);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("%s_valid%0d", tag, k), {31'd0, tv[k]}, 32'd0);
      chk($sformatf("%s_pc%0d", tag, k), tpc[k], 32'd0);
      chk($sformatf("%s_retire_count%0d", tag, k), rcnt[k], 32'd0);
      chk($sformatf("%s_drop_count%0d", tag, k), {16'd0, dcnt[k]}, 32'd0);
      chk($sformatf("%s_overflow%0d", tag, k), {31'd0, ovf[k]}, 32'd0);
      chk($sformatf("%s_halted%0d", tag, k), {31'd0, hlt[k]}, 32'd0);
    end
  endtask

  task automatic do_reset();
    retire_valid = 1'b0;
    reset = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    zero_checks("reset");
    reset = 1'b0;
  endtask

  // Asserts reset mid-cycle and checks outputs before any clock edge occurs.
  task automatic async_reset();
    retire_valid = 1'b0;
    #1;
    reset = 1'b1;
    model_reset();
    #1;
    zero_checks("async");
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    logic [31:0] pc, ins, wd;
    logic [4:0]  wa;
    logic        we;
    model_reset();
    #12;
    do_reset();

    // Three back-to-back addiu retires.
    trace_ready = 1'b1;
    put(32'h0, 32'h24080005, 1'b1, 5'd8,  32'd5);
    put(32'h4, 32'h24090007, 1'b1, 5'd9,  32'd7);
    put(32'h8, 32'h240A000C, 1'b1, 5'd10, 32'd12);
    idle(3);

    // Stalled WB re-presents one instruction four times.
    do_reset();
    for (int i = 0; i < 4; i++) put(32'h10, 32'h01095020, 1'b1, 5'd10, 32'd12);
    idle(3);

    // Bubble and a write to $zero.
    put(32'h14, 32'h0, 1'b1, 5'd5, 32'h99);
    put(32'h18, 32'h24000055, 1'b1, 5'd0, 32'h55);
    idle(3);

    // Overflow: DEPTH+3 distinct retires with the consumer stalled, then push+pop at full.
    do_reset();
    trace_ready = 1'b0;
    for (int i = 0; i < DEPTH + 3; i++)
      put(32'h100 + 32'(4 * i), 32'h24080000 + 32'(i + 1), 1'b1, 5'd8, 32'(i + 1));
    trace_ready = 1'b1;
    put(32'h200, 32'h24090063, 1'b1, 5'd9, 32'd99);
    trace_ready = 1'b0;
    idle(2);
    trace_ready = 1'b1;
    idle(DEPTH + 4);

    // Randomized traffic with repeats, bubbles and consumer stalls.
    do_reset();
    pc = 0; ins = 32'h1; we = 0; wa = 0; wd = 0;
    for (int i = 0; i < 600; i++) begin
      trace_ready = ($urandom_range(0, 3) != 0) || (i % 97 > 70);
      if ((i % 97) > 40 && (i % 97) < 70) trace_ready = 1'b0;
      if ($urandom_range(0, 2) != 0) begin
        if ($urandom_range(0, 2) != 0) begin
          pc  = pc + 4;
          ins = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
          if ($urandom_range(0, 9) == 0) ins = 32'h0000000C;
          we  = 1'($urandom_range(0, 1));
          wa  = 5'($urandom_range(0, 31));
          wd  = $urandom;
        end
        reg_v0 = ($urandom_range(0, 1) != 0) ? 32'h9 : 32'h0;
        put(pc, ins, we, wa, wd);
      end else begin
        idle(1);
      end
    end
    reg_v0 = 32'h0;
    trace_ready = 1'b1;
    idle(DEPTH + 4);

    // End-of-test syscall: only the one with $v0 == 0xA halts.
    do_reset();
    trace_ready = 1'b0;
    reg_v0 = 32'h9;
    put(32'h300, 32'h0000000C, 1'b0, 5'd0, 32'd0);
    reg_v0 = 32'hA;
    put(32'h304, 32'h0000000C, 1'b0, 5'd0, 32'd0);
    put(32'h308, 32'h24080001, 1'b1, 5'd8, 32'd1);
    idle(2);
    async_reset();

    // Five queued records discarded by an asynchronous reset.
    reg_v0 = 32'h0;
    trace_ready = 1'b0;
    for (int i = 0; i < 5; i++)
      put(32'h400 + 32'(4 * i), 32'h24100000 + 32'(i + 1), 1'b1, 5'd16, 32'(i + 7));
    async_reset();

    // Operation resumes after reset.
    trace_ready = 1'b1;
    put(32'h500, 32'h24110042, 1'b1, 5'd17, 32'h42);
    put(32'h504, 32'h24120043, 1'b1, 5'd18, 32'h43);
    idle(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
